tdm_demux16: RTL
================

# tdm_demux16

Receive-side counterpart of the 16-to-1 selector: a 16-slot time-division demultiplexer. A serial bit stream arrives one bit per accepted strobe, and a 4-bit slot counter steers each bit into its slot of a 16-bit shadow register. When a frame completes, the block presents the assembled 16-bit word with a one-cycle valid pulse. It sits at the far end of the serial link driven by the mux-based transmitter and restores the parallel word that transmitter selected slot by slot.

## Interface
- NCH, 16, number of slots per frame; fixed at 16 in this revision.
- SELW, 4, slot counter width, log2(NCH).

- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit/frame_start are sampled only when high
- frame_start  input  1  qualifies the accepted bit as slot 0 of a frame
- sel  output  SELW  slot index the next accepted bit will be written to
- out  output  NCH  last completed frame; slot i lands in out[i]
- out_valid  output  1  one-cycle pulse when out is updated
- sync_err  output  1  one-cycle pulse on a framing violation

## Operation
- Reset values:
  - out=16'h0000, out_valid=0, sel=0, sync_err=0.
  - Shadow register 0, state HUNT.
- State HUNT:
  - Accepted bits without frame_start are discarded; sel stays 0.
  - On in_valid & frame_start: shadow[0]<=in_bit, sel<=1, go to RECV.
- State RECV, on in_valid:
  - Normal bit (frame_start=0, sel!=0): shadow[sel]<=in_bit, sel<=sel+1.
  - Slot 15 accepted: out<={in_bit, shadow[14:0]}, out_valid pulses, sel wraps to 0, stay in RECV.
  - sel==0 and frame_start=1: normal start of the next frame. Back-to-back frames carry no gap.
  - sel==0 and frame_start=0: sync_err pulses, bit dropped, go to HUNT.
  - sel!=0 and frame_start=1 (early start): sync_err pulses, partial frame discarded, bit taken as slot 0, sel<=1, stay in RECV.
- Cycles with in_valid=0 change nothing; gaps of any length are allowed mid-frame.
- out holds its value until the next complete frame. An aborted frame never changes out.
- Shadow bits are overwritten slot by slot and are not cleared between frames.
- rst wins over all other inputs in the same cycle. Reset mid-frame abandons the partial frame; out returns to 0.

## Timing
- Registered outputs throughout; no combinational path from inputs to outputs.
- Latency: out and out_valid update on the clock edge that accepts slot 15.
- out_valid is high for exactly that one cycle; it never asserts on two consecutive cycles unless slot 15 is accepted on two consecutive cycles, which is impossible.
- sync_err asserts on the edge that accepts the offending bit, for one cycle.
- Minimum frame duration is 16 cycles, with in_valid continuously high.

## Structure
- Shared package tdm_pkg:
  - Constants NCH=16 and SELW=4.
  - State encoding HUNT=1'b0, RECV=1'b1.
  - The package is also imported by the transmitter side so slot numbering agrees.
- One sub-module, demux4to16: combinational 4-to-16 one-hot decoder.
  - Inputs: sel and an enable.
  - Outputs: per-slot write enables for the shadow register.
  - It is the structural inverse of mux16to1.
- Top level contains the FSM, slot counter, shadow register and output register.

## Test plan
- Reset then one frame of 16'h3f0a: frame_start on slot 0, slot i = bit i, in_valid continuously high -> out=16'h3f0a and out_valid high exactly one cycle, on the edge accepting slot 15; sel returns to 0.
- Same frame with in_valid low for 3 cycles between slots 5 and 6 -> out=16'h3f0a, out_valid 3 cycles later than the gapless case; sel frozen at 6 during the gap.
- Back-to-back frames 16'hA5A5 then 16'h0001, no idle cycles -> two out_valid pulses 16 cycles apart, out=16'hA5A5 then 16'h0001.
- frame_start re-asserted at slot 9, followed by a full frame 16'hFFFF -> sync_err pulses once at slot 9; no out_valid for the aborted frame; out=16'hFFFF after 16 more bits.
- Frame 16'h1234 completes, then the next bit arrives without frame_start -> sync_err pulses, state HUNT, out stays 16'h1234; further bits are ignored until frame_start.
- rst pulsed after slot 7 of a frame, then a clean frame 16'h8000 -> out=0 and sel=0 the cycle after rst; then out=16'h8000 with a single out_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot numbering and demux state encoding for the TDM link
package tdm_pkg;
  localparam int NCH = 16;
  localparam int SELW = 4;
  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;
endpackage

// File: rtl/tdm_demux16_demux4to16.sv
// demux4to16: one-hot slot write-enable decoder, inverse of mux16to1
module demux4to16
  import tdm_pkg::*;
(
  input  logic [SELW-1:0] sel,
  input  logic            en,
  output logic [NCH-1:0]  wen
);
  always_comb wen = en ? ({{(NCH-1){1'b0}}, 1'b1} << sel) : '0;
endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: 16-slot TDM demultiplexer restoring parallel words from a serial stream
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_bit,
  input  logic            in_valid,
  input  logic            frame_start,
  output logic [SELW-1:0] sel,
  output logic [NCH-1:0]  out,
  output logic            out_valid,
  output logic            sync_err
);
  state_t state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, wr_sel;
  logic [NCH-1:0] shadow_q, shadow_d, out_q, out_d, wen;
  logic out_valid_q, out_valid_d, sync_err_q, sync_err_d, wr_en;
  // frame_start always lands in slot 0, whether a clean start or an early restart
  assign wr_sel = frame_start ? '0 : sel_q;
  assign wr_en = in_valid & (frame_start | (state_q == RECV && sel_q != '0));
  demux4to16 u_dec (.sel(wr_sel), .en(wr_en), .wen(wen));
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    out_d = out_q;
    out_valid_d = 1'b0;
    sync_err_d = 1'b0;
    shadow_d = (shadow_q & ~wen) | (wen & {NCH{in_bit}});
    if (in_valid) begin
      if (frame_start) begin
        sync_err_d = (state_q == RECV) && (sel_q != '0);
        sel_d = SELW'(1);
        state_d = RECV;
      end else if (state_q == RECV) begin
        if (sel_q == '0) begin
          sync_err_d = 1'b1;
          state_d = HUNT;
        end else begin
          sel_d = sel_q + 1'b1;
          if (sel_q == SELW'(NCH-1)) begin
            out_d = {in_bit, shadow_q[NCH-2:0]};
            out_valid_d = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q <= '0;
      shadow_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      shadow_q <= shadow_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q <= sync_err_d;
    end
  end
  assign sel = sel_q;
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign sync_err = sync_err_q;
endmodule
